// File: rtl/iccm_port_arb_if.sv
// Bundle of the two requester ports, the program-mode lock and the SRAM
// macro port of the ICCM arbiter. The slave side is the arbiter itself;
// the master side drives the requests and the SRAM read data.
interface iccm_port_arb_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  // requester 0 (bus adapter)
  logic                  r0_req_i;
  logic                  r0_we_i;
  logic [ADDR_WIDTH-1:0] r0_addr_i;
  logic [DATA_WIDTH-1:0] r0_wdata_i;
  logic [NUM_WMASKS-1:0] r0_wmask_i;
  logic                  r0_gnt_o;
  logic                  r0_rvalid_o;
  logic [DATA_WIDTH-1:0] r0_rdata_o;
  // requester 1 (program loader)
  logic                  r1_req_i;
  logic                  r1_we_i;
  logic [ADDR_WIDTH-1:0] r1_addr_i;
  logic [DATA_WIDTH-1:0] r1_wdata_i;
  logic [NUM_WMASKS-1:0] r1_wmask_i;
  logic                  r1_gnt_o;
  logic                  r1_rvalid_o;
  logic [DATA_WIDTH-1:0] r1_rdata_o;
  logic                  r1_lock_i;
  // SRAM macro port
  logic                  csb_o;
  logic                  web_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [NUM_WMASKS-1:0] wmask_o;
  logic [DATA_WIDTH-1:0] rdata_i;
  // statistics
  logic [15:0]           conflict_cnt_o;

  modport slave (
    input  r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i, r0_wmask_i,
    output r0_gnt_o, r0_rvalid_o, r0_rdata_o,
    input  r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i, r1_wmask_i, r1_lock_i,
    output r1_gnt_o, r1_rvalid_o, r1_rdata_o,
    output csb_o, web_o, addr_o, wdata_o, wmask_o,
    input  rdata_i,
    output conflict_cnt_o
  );

  modport master (
    output r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i, r0_wmask_i,
    input  r0_gnt_o, r0_rvalid_o, r0_rdata_o,
    output r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i, r1_wmask_i, r1_lock_i,
    input  r1_gnt_o, r1_rvalid_o, r1_rdata_o,
    input  csb_o, web_o, addr_o, wdata_o, wmask_o,
    output rdata_i,
    input  conflict_cnt_o
  );
endinterface

// File: rtl/iccm_port_arb.sv
// Two-requester arbiter in front of a single-port ICCM SRAM macro.
// Grants are combinational so one access can be issued every cycle;
// read data comes back one cycle later and is steered to the owner.
// Requester 1 can lock the SRAM for exclusive use in program mode.
module iccm_port_arb #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  iccm_port_arb_if.slave  bus
);

  logic        last_gnt_q;   // index of the most recently granted requester
  logic        pend_q;       // a read was issued last cycle
  logic        owner_q;      // requester that owns the pending read
  logic [15:0] cnt_q;        // saturating contention counter

  logic        gnt0_d;
  logic        gnt1_d;
  logic        contend_d;

  // Grant decision: lock hands the SRAM to r1 alone; otherwise a lone
  // requester wins and contention alternates away from the last winner.
  always_comb begin
    contend_d = bus.r0_req_i & bus.r1_req_i & ~bus.r1_lock_i;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    if (!rst_i) begin
      if (bus.r1_lock_i) begin
        gnt1_d = bus.r1_req_i;
      end else if (contend_d) begin
        gnt0_d = last_gnt_q;
        gnt1_d = ~last_gnt_q;
      end else begin
        gnt0_d = bus.r0_req_i;
        gnt1_d = bus.r1_req_i;
      end
    end
  end

  // SRAM port mux: fields of the winner, reads enable every byte lane,
  // and an idle cycle parks the port with zeroed fields.
  always_comb begin
    bus.csb_o   = 1'b1;
    bus.web_o   = 1'b1;
    bus.addr_o  = '0;
    bus.wdata_o = '0;
    bus.wmask_o = '0;
    if (gnt0_d) begin
      bus.csb_o   = 1'b0;
      bus.web_o   = ~bus.r0_we_i;
      bus.addr_o  = bus.r0_addr_i;
      bus.wdata_o = bus.r0_wdata_i;
      bus.wmask_o = bus.r0_we_i ? bus.r0_wmask_i : {NUM_WMASKS{1'b1}};
    end else if (gnt1_d) begin
      bus.csb_o   = 1'b0;
      bus.web_o   = ~bus.r1_we_i;
      bus.addr_o  = bus.r1_addr_i;
      bus.wdata_o = bus.r1_wdata_i;
      bus.wmask_o = bus.r1_we_i ? bus.r1_wmask_i : {NUM_WMASKS{1'b1}};
    end
  end

  // Arbitration history, read tracking and contention statistics.
  // Reset leaves last_gnt at 1 so requester 0 wins the first contention,
  // and clears any read in flight so its data is never returned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_gnt_q <= 1'b1;
      pend_q     <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (gnt0_d | gnt1_d) begin
        last_gnt_q <= gnt1_d;
      end
      pend_q  <= (gnt0_d & ~bus.r0_we_i) | (gnt1_d & ~bus.r1_we_i);
      owner_q <= gnt1_d;
      if (contend_d && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Response steering: the pending read's data goes to its owner only.
  always_comb begin
    bus.r0_gnt_o       = gnt0_d;
    bus.r1_gnt_o       = gnt1_d;
    bus.r0_rvalid_o    = pend_q & ~owner_q;
    bus.r1_rvalid_o    = pend_q & owner_q;
    bus.r0_rdata_o     = bus.r0_rvalid_o ? bus.rdata_i : '0;
    bus.r1_rdata_o     = bus.r1_rvalid_o ? bus.rdata_i : '0;
    bus.conflict_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_iccm_port_arb.sv
// Directed bench for iccm_port_arb: a cycle-level reference model
// predicts every output on every cycle, and literal expectations pin the
// model at the key points of each scenario.
module tb_iccm_port_arb;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  iccm_port_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) bus ();

  iccm_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // State of the model: who won last, whether a read is owed to whom,
  // and the contention count.
  int          m_last  = 1;
  bit          m_pend  = 0;
  int          m_owner = 0;
  int unsigned m_cnt   = 0;

  // Which requester the arbitration rules pick this cycle (-1 for none).
  function automatic int winner();
    if (rst) return -1;
    if (bus.r1_lock_i) return bus.r1_req_i ? 1 : -1;
    if (bus.r0_req_i && bus.r1_req_i) return 1 - m_last;
    if (bus.r0_req_i) return 0;
    if (bus.r1_req_i) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_last = 1; m_pend = 0; m_owner = 0; m_cnt = 0;
    end else begin
      w = winner();
      m_pend = 0;
      if (w >= 0) begin
        m_last  = w;
        m_owner = w;
        m_pend  = (w == 0) ? !bus.r0_we_i : !bus.r1_we_i;
      end
      if (bus.r0_req_i && bus.r1_req_i && !bus.r1_lock_i && m_cnt < 32'hFFFF)
        m_cnt = m_cnt + 1;
    end
  end

  // Every-cycle comparison, mid-cycle when inputs and outputs are stable.
  always @(negedge clk) begin
    int w;
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    bit rv0, rv1;
    w   = winner();
    we  = (w == 1) ? bus.r1_we_i    : bus.r0_we_i;
    a   = (w == 1) ? bus.r1_addr_i  : bus.r0_addr_i;
    d   = (w == 1) ? bus.r1_wdata_i : bus.r0_wdata_i;
    m   = (w == 1) ? bus.r1_wmask_i : bus.r0_wmask_i;
    rv0 = m_pend && m_owner == 0;
    rv1 = m_pend && m_owner == 1;
    check("model_gnt", {bus.r0_gnt_o, bus.r1_gnt_o}, {w == 0, w == 1});
    check("model_csb_web", {bus.csb_o, bus.web_o}, {w < 0, (w < 0) ? 1'b1 : !we});
    check("model_addr", bus.addr_o, (w < 0) ? '0 : a);
    check("model_wdata", bus.wdata_o, (w < 0) ? '0 : d);
    check("model_wmask", bus.wmask_o, (w < 0) ? '0 : (we ? m : {MW{1'b1}}));
    check("model_rvalid", {bus.r0_rvalid_o, bus.r1_rvalid_o}, {rv0, rv1});
    check("model_r0_rdata", bus.r0_rdata_o, rv0 ? bus.rdata_i : '0);
    check("model_r1_rdata", bus.r1_rdata_o, rv1 ? bus.rdata_i : '0);
    check("model_cnt", bus.conflict_cnt_o, m_cnt[15:0]);
  end

  // ---------------- stimulus ----------------
  // One cycle: drive after the rising edge, return just after the
  // falling edge so literal checks see settled outputs.
  task automatic step(
    input logic r, input logic lk,
    input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic [MW-1:0] m0,
    input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [MW-1:0] m1,
    input logic [DW-1:0] rd);
    @(posedge clk); #1;
    rst = r;
    bus.r1_lock_i = lk;
    bus.r0_req_i = q0; bus.r0_we_i = w0; bus.r0_addr_i = a0; bus.r0_wdata_i = d0; bus.r0_wmask_i = m0;
    bus.r1_req_i = q1; bus.r1_we_i = w1; bus.r1_addr_i = a1; bus.r1_wdata_i = d1; bus.r1_wmask_i = m1;
    bus.rdata_i = rd;
    @(negedge clk); #1;
    $display("t=%0t rst=%0b lock=%0b req=%0b%0b gnt=%0b%0b csb=%0b web=%0b addr=%0h rvalid=%0b%0b cnt=%0h",
             $time, rst, lk, q0, q1, bus.r0_gnt_o, bus.r1_gnt_o, bus.csb_o, bus.web_o,
             bus.addr_o, bus.r0_rvalid_o, bus.r1_rvalid_o, bus.conflict_cnt_o);
  endtask

  task automatic idle(input logic [DW-1:0] rd);
    step(0, 0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, rd);
  endtask

  task automatic both_read(input logic [DW-1:0] rd);
    step(0, 0, 1, 0, 11'h100, '0, '0, 1, 0, 11'h200, '0, '0, rd);
  endtask

  initial begin
    bus.r1_lock_i = 0;
    bus.r0_req_i = 1; bus.r0_we_i = 0; bus.r0_addr_i = '0; bus.r0_wdata_i = '0; bus.r0_wmask_i = '0;
    bus.r1_req_i = 1; bus.r1_we_i = 0; bus.r1_addr_i = '0; bus.r1_wdata_i = '0; bus.r1_wmask_i = '0;
    bus.rdata_i = 32'hA5A5A5A5;

    // reset state, requests present but grants gated
    @(negedge clk); #1;
    check("rst_gnt", {bus.r0_gnt_o, bus.r1_gnt_o}, 2'b00);
    check("rst_csb_web", {bus.csb_o, bus.web_o}, 2'b11);
    check("rst_cnt", bus.conflict_cnt_o, 16'h0000);
    check("rst_rvalid", {bus.r0_rvalid_o, bus.r1_rvalid_o}, 2'b00);

    // single r0 read at 0x010
    step(0, 0, 1, 0, 11'h010, '0, 4'h0, 0, 0, '0, '0, '0, 32'h0);
    check("rd_gnt", {bus.r0_gnt_o, bus.r1_gnt_o}, 2'b10);
    check("rd_csb_web", {bus.csb_o, bus.web_o}, 2'b01);
    check("rd_addr", bus.addr_o, 11'h010);
    check("rd_wmask", bus.wmask_o, 4'hF);
    idle(32'hDEADBEEF);
    check("rd_rvalid", {bus.r0_rvalid_o, bus.r1_rvalid_o}, 2'b10);
    check("rd_rdata", bus.r0_rdata_o, 32'hDEADBEEF);
    idle(32'h11111111);
    check("rd_rvalid_once", bus.r0_rvalid_o, 1'b0);

    // reset pulsed the cycle after a read grant drops the response
    step(0, 0, 1, 0, 11'h033, '0, '0, 0, 0, '0, '0, '0, 32'h0);
    step(1, 0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 32'hCAFEF00D);
    check("rstmid_rvalid", bus.r0_rvalid_o, 1'b0);
    check("rstmid_rdata", bus.r0_rdata_o, 32'h0);
    check("rstmid_csb", bus.csb_o, 1'b1);
    idle(32'hCAFEF00D);
    check("rstmid_after", {bus.r0_rvalid_o, bus.r1_rvalid_o}, 2'b00);

    // continuous contention: r0, r1, r0, r1
    both_read(32'h0);
    check("rr_g1", {bus.r0_gnt_o, bus.r1_gnt_o}, 2'b10);
    both_read(32'h1000);
    check("rr_g2", {bus.r0_gnt_o, bus.r1_gnt_o}, 2'b01);
    check("rr_rv1", bus.r0_rdata_o, 32'h1000);
    both_read(32'h2000);
    check("rr_g3", {bus.r0_gnt_o, bus.r1_gnt_o}, 2'b10);
    check("rr_rv2", bus.r1_rdata_o, 32'h2000);
    both_read(32'h3000);
    check("rr_g4", {bus.r0_gnt_o, bus.r1_gnt_o}, 2'b01);
    idle(32'h4000);
    check("rr_cnt", bus.conflict_cnt_o, 16'd4);
    check("rr_last_rv", bus.r1_rvalid_o, 1'b1);

    // locked r1 write with r0 also requesting
    step(0, 1, 1, 0, 11'h055, '0, '0, 1, 1, 11'h7FF, 32'h12345678, 4'b0011, 32'h0);
    check("lk_gnt", {bus.r0_gnt_o, bus.r1_gnt_o}, 2'b01);
    check("lk_web", bus.web_o, 1'b0);
    check("lk_wmask", bus.wmask_o, 4'b0011);
    check("lk_addr_data", {bus.addr_o, bus.wdata_o}, {11'h7FF, 32'h12345678});
    idle(32'h5555);
    check("lk_cnt", bus.conflict_cnt_o, 16'd4);
    check("lk_norv", {bus.r0_rvalid_o, bus.r1_rvalid_o}, 2'b00);

    // lock raised the cycle after an r0 read grant
    step(0, 0, 1, 0, 11'h020, '0, '0, 0, 0, '0, '0, '0, 32'h0);
    step(0, 1, 1, 0, 11'h021, '0, '0, 0, 0, '0, '0, '0, 32'h77665544);
    check("lkmid_rv", bus.r0_rvalid_o, 1'b1);
    check("lkmid_rdata", bus.r0_rdata_o, 32'h77665544);
    check("lkmid_gnt", bus.r0_gnt_o, 1'b0);
    step(0, 1, 1, 0, 11'h022, '0, '0, 0, 0, '0, '0, '0, 32'h0);
    check("lkmid_rv_once", bus.r0_rvalid_o, 1'b0);
    check("lkmid_gnt2", bus.r0_gnt_o, 1'b0);

    // back-to-back r0 reads, then an r1 read and a mixed write/read fight
    step(0, 0, 1, 0, 11'h040, '0, '0, 0, 0, '0, '0, '0, 32'h0);
    step(0, 0, 1, 0, 11'h041, '0, '0, 0, 0, '0, '0, '0, 32'hB0);
    check("b2b_rv", {bus.r0_gnt_o, bus.r0_rvalid_o}, 2'b11);
    step(0, 0, 1, 0, 11'h042, '0, '0, 0, 0, '0, '0, '0, 32'hB1);
    step(0, 0, 0, 0, '0, '0, '0, 1, 0, 11'h300, '0, '0, 32'hB2);
    step(0, 0, 1, 1, 11'h301, 32'hABCD, 4'b1000, 1, 0, 11'h302, '0, '0, 32'hB3);
    step(0, 0, 1, 1, 11'h303, 32'hEF01, 4'b0100, 1, 0, 11'h304, '0, '0, 32'hB4);
    idle(32'hB5);

    // saturation of the contention counter
    @(posedge clk); #1;
    force dut.cnt_q = 16'hFFFE;
    m_cnt = 32'hFFFE;
    #1;
    release dut.cnt_q;
    both_read(32'h0);
    both_read(32'h0);
    check("sat_1", bus.conflict_cnt_o, 16'hFFFF);
    both_read(32'h0);
    idle(32'h0);
    check("sat_hold", bus.conflict_cnt_o, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iccm_port_arb.md
ICCM_PORT_ARB -- requirements
Module: iccm_port_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM data width.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, byte-mask width (DATA_WIDTH/8).
REQ-004 SHALL have port clk_i, in, 1, the only clock.
REQ-005 SHALL have port rst_i, in, 1; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports r0_req_i, r0_we_i (in, 1 each): requester 0 (bus adapter) access request and write flag.
REQ-007 SHALL have ports r0_addr_i (in, ADDR_WIDTH), r0_wdata_i (in, DATA_WIDTH), r0_wmask_i (in, NUM_WMASKS): requester 0 access fields.
REQ-008 SHALL have ports r0_gnt_o, r0_rvalid_o (out, 1 each) and r0_rdata_o (out, DATA_WIDTH): requester 0 grant, read-valid and read data.
REQ-009 SHALL have the same set of ports prefixed r1_ for requester 1 (program loader).
REQ-010 SHALL have port r1_lock_i, in, 1: program-mode lock giving requester 1 exclusive ownership.
REQ-011 SHALL have ports csb_o, web_o, out, 1 each: SRAM chip select and write enable, both active-low.
REQ-012 SHALL have ports addr_o (out, ADDR_WIDTH), wdata_o (out, DATA_WIDTH), wmask_o (out, NUM_WMASKS): SRAM access fields.
REQ-013 SHALL have port rdata_i, in, DATA_WIDTH: SRAM read data, valid one clk_i cycle after the access cycle.
REQ-014 SHALL have port conflict_cnt_o, out, 16: saturating count of contention cycles.

Function
REQ-015 SHALL issue at most one SRAM access per cycle; the grant is combinational and the access is driven in the same cycle as the grant.
REQ-016 SHALL, when r1_lock_i=1, grant only r1; r0_gnt_o SHALL be 0 regardless of r0_req_i.
REQ-017 SHALL, when unlocked and exactly one requester requests, grant that requester.
REQ-018 SHALL, when unlocked and both request, grant the requester other than last_gnt (round-robin).
REQ-019 SHALL keep a 1-bit register last_gnt, updated at each clock edge to the index of the granted requester and held when there is no grant.
REQ-020 SHALL, on a grant, drive csb_o=0, web_o=~we, and addr_o/wdata_o/wmask_o from the granted requester; wmask_o SHALL be all-ones on reads.
REQ-021 SHALL, with no grant, drive csb_o=1 and web_o=1; addr_o, wdata_o and wmask_o SHALL then be 0.
REQ-022 SHALL register, for each granted read, a pending flag and the owner index; rN_rvalid_o SHALL be 1 in the next cycle for the owner only, for exactly one cycle.
REQ-023 SHALL drive rN_rdata_o = rdata_i while rN_rvalid_o=1, and 0 otherwise.
REQ-024 SHALL NOT assert rvalid for writes.
REQ-025 SHALL support back-to-back grants, giving a throughput of one access per cycle; a new access SHALL be accepted in the same cycle a previous read's rvalid is asserted.
REQ-026 SHALL increment conflict_cnt_o on each cycle with r0_req_i=1, r1_req_i=1 and r1_lock_i=0; the count SHALL saturate at 16'hFFFF.
REQ-027 SHALL treat a lock assertion in the middle of an r0 read as follows: the read already granted SHALL still complete its rvalid, and subsequent r0 requests SHALL be blocked.
REQ-028 SHALL keep round-robin fairness such that no requester waits more than 1 cycle while both request continuously and the block is unlocked.

Reset
REQ-029 SHALL, while rst_i=1 (asynchronous), force the following: last_gnt=1 (so r0 wins first contention), pending=0, conflict_cnt_o=0, r0/r1_rvalid_o=0, rdata outputs=0, csb_o=1, web_o=1.
REQ-030 SHALL gate the grant outputs to 0 while rst_i=1.
REQ-031 SHALL, on reset asserted mid-read, cause the pending rvalid to be dropped and not emitted after release.

Verification
REQ-032 Single r0 read at addr 0x010 with rdata_i=0xDEADBEEF -> r0_gnt_o=1, csb_o=0, web_o=1 in the same cycle; r0_rvalid_o=1 and r0_rdata_o=0xDEADBEEF in the next cycle.
REQ-033 Both requesting continuously for 4 cycles after reset -> grants r0,r1,r0,r1; conflict_cnt_o=4.
REQ-034 r1_lock_i=1 with r1 write to addr 0x7FF, data 0x12345678, mask 4'b0011, and r0 requesting -> only r1_gnt_o=1, web_o=0, wmask_o=0011; conflict_cnt_o unchanged; no rvalid.
REQ-035 Lock raised in the cycle after an r0 read grant -> r0_rvalid_o still pulses once; r0_gnt_o stays 0 while locked.
REQ-036 Force conflict_cnt_o to 16'hFFFE, then 3 contention cycles -> count holds at 16'hFFFF.
REQ-037 rst_i pulsed in the cycle after a read grant -> no rvalid, csb_o=1, next contention won by r0.
